// File: rtl/iir_pkg.sv
// Shared constants and sample type for the IIR filter datapath and its output buffer.
package iir_pkg;

    localparam int NB        = 12;
    localparam int DW        = NB + 1;
    localparam int DEPTH_DEF = 8;
    localparam int AW_DEF    = 3;
    localparam int DCW_DEF   = 8;

    typedef logic signed [DW-1:0] sample_t;

endpackage

// File: rtl/iir_fifo_mem.sv
// Register-file storage for the output FIFO: one synchronous write port, one asynchronous read port.
module iir_fifo_mem
    import iir_pkg::*;
#(
    parameter int WIDTH = iir_pkg::DW,
    parameter int DEPTH = iir_pkg::DEPTH_DEF,
    parameter int AW    = iir_pkg::AW_DEF
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/iir_out_fifo.sv
// Show-ahead output FIFO behind iir_filter with a valid/ready consumer side and overflow accounting.
module iir_out_fifo
    import iir_pkg::*;
#(
    parameter int NB    = iir_pkg::NB,
    parameter int DEPTH = iir_pkg::DEPTH_DEF,
    parameter int AW    = iir_pkg::AW_DEF,
    parameter int DCW   = iir_pkg::DCW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           vIn,
    input  logic [NB:0]    dIn,
    input  logic           rdy,
    input  logic           clr,
    output logic           vOut,
    output logic [NB:0]    dOut,
    output logic           full,
    output logic           empty,
    output logic [AW:0]    count,
    output logic           ovf,
    output logic [DCW-1:0] drop_cnt
);

    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [AW-1:0]  wrPtr_q, wrPtr_d;
    logic [AW-1:0]  rdPtr_q, rdPtr_d;
    logic [AW:0]    count_q, count_d;
    logic           ovf_q, ovf_d;
    logic [DCW-1:0] dropCnt_q, dropCnt_d;
    logic [NB:0]    rdData;
    logic           pop;
    logic           pushOk;
    logic           drop;

    assign full   = (count_q == CNT_FULL);
    assign empty  = (count_q == '0);
    assign vOut   = !empty;
    assign pop    = vOut && rdy;
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign pushOk = vIn && (!full || pop);
    assign drop   = vIn && full && !pop;

    iir_fifo_mem #(
        .WIDTH (NB + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (pushOk),
        .waddr_i (wrPtr_q),
        .wdata_i (dIn),
        .raddr_i (rdPtr_q),
        .rdata_o (rdData)
    );

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (pushOk) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        unique case ({pushOk, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // clr wins over a simultaneous drop, so that sample is never counted.
    always_comb begin
        ovf_d     = ovf_q;
        dropCnt_d = dropCnt_q;
        if (clr) begin
            ovf_d     = 1'b0;
            dropCnt_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (dropCnt_q != '1) begin
                dropCnt_d = dropCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            dropCnt_q <= '0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            dropCnt_q <= dropCnt_d;
        end
    end

    assign dOut     = empty ? '0 : rdData;
    assign count    = count_q;
    assign ovf      = ovf_q;
    assign drop_cnt = dropCnt_q;

endmodule

// File: tb/tb_iir_out_fifo.sv
// Directed self-checking bench for iir_out_fifo, including a narrow drop-counter build for saturation.
module tb_iir_out_fifo;

    logic        clk;
    logic        rst;
    logic        vIn;
    logic [12:0] dIn;
    logic        rdy;
    logic        clr;

    logic        vOut, full, empty, ovf;
    logic [12:0] dOut;
    logic [3:0]  count;
    logic [7:0]  drop_cnt;

    logic        vOut2, full2, empty2, ovf2;
    logic [12:0] dOut2;
    logic [3:0]  count2;
    logic [1:0]  drop_cnt2;

    int nChecks;
    int nFail;

    iir_out_fifo #(.NB(12), .DEPTH(8), .AW(3), .DCW(8)) dut (
        .clk(clk), .rst(rst), .vIn(vIn), .dIn(dIn), .rdy(rdy), .clr(clr),
        .vOut(vOut), .dOut(dOut), .full(full), .empty(empty), .count(count),
        .ovf(ovf), .drop_cnt(drop_cnt)
    );

    iir_out_fifo #(.NB(12), .DEPTH(8), .AW(3), .DCW(2)) dutSat (
        .clk(clk), .rst(rst), .vIn(vIn), .dIn(dIn), .rdy(rdy), .clr(clr),
        .vOut(vOut2), .dOut(dOut2), .full(full2), .empty(empty2), .count(count2),
        .ovf(ovf2), .drop_cnt(drop_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; vIn = 1'b0; dIn = '0; rdy = 1'b0; clr = 1'b0;
        tick();
        tick();
        nChecks++;
        if (empty !== 1'b1 || count !== 4'd0 || vOut !== 1'b0 || dOut !== 13'd0 || ovf !== 1'b0 || drop_cnt !== 8'd0) begin
            nFail++;
            $display("[TB] FAIL reset_state: empty=%b count=%0d vOut=%b dOut=%h ovf=%b drop=%0d, required 1 0 0 0 0 0",
                     empty, count, vOut, dOut, ovf, drop_cnt);
        end
        rst = 1'b0;
        tick();
        for (int i = 1; i <= 3; i++) begin
            vIn = 1'b1; dIn = 13'(i + 40);
            tick();
        end
        vIn = 1'b0;
        nChecks++;
        if (count !== 4'd3 || vOut !== 1'b1 || dOut !== 13'd41) begin
            nFail++;
            $display("[TB] FAIL pre_reset_fill: count=%0d vOut=%b dOut=%h, required 3 1 029", count, vOut, dOut);
        end
        #2;
        rst = 1'b1;
        #1;
        nChecks++;
        if (empty !== 1'b1 || count !== 4'd0 || vOut !== 1'b0 || dOut !== 13'd0 || ovf !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL async_reset: empty=%b count=%0d vOut=%b dOut=%h ovf=%b, required 1 0 0 0 0",
                     empty, count, vOut, dOut, ovf);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        vIn = 1'b1; dIn = 13'h0A5; rdy = 1'b0;
        tick();
        vIn = 1'b0;
        nChecks++;
        if (vOut !== 1'b1 || dOut !== 13'h0A5 || count !== 4'd1) begin
            nFail++;
            $display("[TB] FAIL single_visible: vOut=%b dOut=%h count=%0d, required 1 0a5 1", vOut, dOut, count);
        end
        tick();
        nChecks++;
        if (vOut !== 1'b1 || dOut !== 13'h0A5) begin
            nFail++;
            $display("[TB] FAIL single_hold: vOut=%b dOut=%h, required 1 0a5", vOut, dOut);
        end
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        nChecks++;
        if (empty !== 1'b1 || dOut !== 13'd0 || vOut !== 1'b0 || count !== 4'd0) begin
            nFail++;
            $display("[TB] FAIL single_pop: empty=%b dOut=%h vOut=%b count=%0d, required 1 0 0 0", empty, dOut, vOut, count);
        end
    endtask

    task automatic test_fill_drain_wrap();
        int got;
        rdy = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            vIn = 1'b1; dIn = 13'(i);
            tick();
        end
        vIn = 1'b0;
        nChecks++;
        if (full !== 1'b1 || count !== 4'd8) begin
            nFail++;
            $display("[TB] FAIL fill_full: full=%b count=%0d, required 1 8", full, count);
        end
        got = 0;
        rdy = 1'b1;
        for (int i = 9; i <= 12; i++) begin
            vIn = 1'b1; dIn = 13'(i);
            got++;
            nChecks++;
            if (vOut !== 1'b1 || dOut !== 13'(got)) begin
                nFail++;
                $display("[TB] FAIL wrap_order_%0d: vOut=%b dOut=%0d, required 1 %0d", got, vOut, dOut, got);
            end
            tick();
            nChecks++;
            if (count !== 4'd8) begin
                nFail++;
                $display("[TB] FAIL wrap_count_%0d: count=%0d, required 8", got, count);
            end
        end
        vIn = 1'b0;
        for (int c = 0; c < 20 && vOut; c++) begin
            got++;
            nChecks++;
            if (dOut !== 13'(got)) begin
                nFail++;
                $display("[TB] FAIL drain_order_%0d: dOut=%0d, required %0d", got, dOut, got);
            end
            tick();
        end
        rdy = 1'b0;
        nChecks++;
        if (got !== 12 || empty !== 1'b1 || ovf !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL drain_total: popped=%0d empty=%b ovf=%b, required 12 1 0", got, empty, ovf);
        end
    endtask

    task automatic test_overflow();
        rdy = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            vIn = 1'b1; dIn = 13'(i);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            vIn = 1'b1; dIn = 13'h0777;
            tick();
            vIn = 1'b0;
            tick();
        end
        nChecks++;
        if (ovf !== 1'b1 || drop_cnt !== 8'd3 || count !== 4'd8 || dOut !== 13'd1) begin
            nFail++;
            $display("[TB] FAIL overflow: ovf=%b drop=%0d count=%0d head=%0d, required 1 3 8 1", ovf, drop_cnt, count, dOut);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        nChecks++;
        if (ovf !== 1'b0 || drop_cnt !== 8'd0 || count !== 4'd8) begin
            nFail++;
            $display("[TB] FAIL clear: ovf=%b drop=%0d count=%0d, required 0 0 8", ovf, drop_cnt, count);
        end
    endtask

    task automatic test_full_push_pop();
        logic [12:0] expSeq [9];
        int          got;
        for (int i = 0; i < 8; i++) expSeq[i] = 13'(i + 1);
        expSeq[8] = 13'h1FFF;
        got = 0;
        vIn = 1'b1; dIn = 13'h1FFF; rdy = 1'b1;
        nChecks++;
        if (dOut !== expSeq[0]) begin
            nFail++;
            $display("[TB] FAIL pushpop_head: dOut=%h, required %h", dOut, expSeq[0]);
        end
        got = 1;
        tick();
        vIn = 1'b0; rdy = 1'b0;
        nChecks++;
        if (count !== 4'd8 || ovf !== 1'b0 || drop_cnt !== 8'd0) begin
            nFail++;
            $display("[TB] FAIL pushpop_full: count=%0d ovf=%b drop=%0d, required 8 0 0", count, ovf, drop_cnt);
        end
        rdy = 1'b1;
        for (int c = 0; c < 20 && vOut; c++) begin
            nChecks++;
            if (got > 8 || dOut !== expSeq[got]) begin
                nFail++;
                $display("[TB] FAIL pushpop_order_%0d: dOut=%h, required %h", got, dOut, expSeq[got > 8 ? 8 : got]);
            end
            got++;
            tick();
        end
        rdy = 1'b0;
        nChecks++;
        if (got !== 9 || empty !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL pushpop_total: popped=%0d empty=%b, required 9 1", got, empty);
        end
    endtask

    task automatic test_saturation();
        rdy = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            vIn = 1'b1; dIn = 13'(i);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            vIn = 1'b1; dIn = 13'h1000;
            tick();
        end
        vIn = 1'b0;
        nChecks++;
        if (drop_cnt2 !== 2'd3 || ovf2 !== 1'b1 || count2 !== 4'd8) begin
            nFail++;
            $display("[TB] FAIL sat_hold: drop=%0d ovf=%b count=%0d, required 3 1 8", drop_cnt2, ovf2, count2);
        end
        nChecks++;
        if (drop_cnt !== 8'd5) begin
            nFail++;
            $display("[TB] FAIL wide_drop: drop=%0d, required 5", drop_cnt);
        end
        vIn = 1'b1; clr = 1'b1;
        tick();
        vIn = 1'b0; clr = 1'b0;
        nChecks++;
        if (drop_cnt2 !== 2'd0 || ovf2 !== 1'b0 || drop_cnt !== 8'd0 || ovf !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL clr_priority: drop2=%0d ovf2=%b drop=%0d ovf=%b, required 0 0 0 0",
                     drop_cnt2, ovf2, drop_cnt, ovf);
        end
        nChecks++;
        if (count2 !== 4'd8 || dOut2 !== 13'd1) begin
            nFail++;
            $display("[TB] FAIL clr_contents: count=%0d head=%0d, required 8 1", count2, dOut2);
        end
    endtask

    initial begin
        nChecks = 0;
        nFail   = 0;
        test_reset();
        test_single();
        test_fill_drain_wrap();
        test_overflow();
        test_full_push_pop();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
